// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared types and ASCII helpers for the drive-command link.
// Used by uart_cmd_rx, uart_rx_byte and command_translator.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    CMD_STOP  = 3'd0,
    CMD_FWD   = 3'd1,
    CMD_BACK  = 3'd2,
    CMD_LEFT  = 3'd3,
    CMD_RIGHT = 3'd4
  } drive_cmd_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  typedef enum logic {
    MSG_WAIT_CMD,
    MSG_WAIT_MULT
  } msg_state_e;

  localparam logic [7:0] ASCII_S = 8'h53;
  localparam logic [7:0] ASCII_F = 8'h46;
  localparam logic [7:0] ASCII_B = 8'h42;
  localparam logic [7:0] ASCII_L = 8'h4C;
  localparam logic [7:0] ASCII_R = 8'h52;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_7 = 8'h37;

  function automatic logic is_cmd_letter(
    input logic [7:0] c
  );
    return (c == ASCII_S) || (c == ASCII_F) ||
           (c == ASCII_B) || (c == ASCII_L) ||
           (c == ASCII_R);
  endfunction

  function automatic logic is_digit(
    input logic [7:0] c
  );
    return (c >= ASCII_0) && (c <= ASCII_7);
  endfunction

  function automatic drive_cmd_e ascii_to_cmd(
    input logic [7:0] c
  );
    drive_cmd_e r;
    r = CMD_STOP;
    unique case (1'b1)
      (c == ASCII_F): r = CMD_FWD;
      (c == ASCII_B): r = CMD_BACK;
      (c == ASCII_L): r = CMD_LEFT;
      (c == ASCII_R): r = CMD_RIGHT;
      default:        r = CMD_STOP;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 2-flop synchroniser plus 8N1 byte receiver.
// Ports: clk, reset, uart_in -> data[7:0], byte_valid, frame_err.
module uart_rx_byte
  import uart_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_in,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic          sync0;
  logic          sync1;
  logic [1:0]    fill;
  logic          prev;
  rx_state_e     state;
  rx_state_e     state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_n;
  logic [7:0]    shreg;
  logic [7:0]    sh_n;
  logic          bv_n;
  logic          fe_n;

  assign data = shreg;

  // fill marks when sync1 holds a real line sample rather than
  // its reset value; prev only reads high on a genuinely high
  // line, so a line held low through reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync0      <= 1'b1;
      sync1      <= 1'b1;
      fill       <= 2'b00;
      prev       <= 1'b0;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync0      <= uart_in;
      sync1      <= sync0;
      fill       <= {fill[0], 1'b1};
      prev       <= sync1 & fill[1];
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      shreg      <= sh_n;
      byte_valid <= bv_n;
      frame_err  <= fe_n;
    end
  end

  // cnt equals the cycles elapsed since the last reference point
  // (start edge or previous sample).
  always_comb begin
    state_n = state;
    cnt_n   = cnt + ONE;
    bit_n   = bit_idx;
    sh_n    = shreg;
    bv_n    = 1'b0;
    fe_n    = 1'b0;
    unique case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (prev && !sync1) begin
          state_n = RX_START;
          cnt_n   = ONE;
        end
      end
      RX_START: begin
        if (cnt == HALF) begin
          cnt_n   = ONE;
          bit_n   = '0;
          state_n = sync1 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == FULL) begin
          cnt_n = ONE;
          sh_n  = {sync1, shreg[7:1]};
          bit_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_n = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (cnt == FULL) begin
          cnt_n = '0;
          if (sync1) begin
            bv_n    = 1'b1;
            state_n = RX_IDLE;
          end else begin
            fe_n    = 1'b1;
            state_n = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        cnt_n = '0;
        if (sync1) begin
          state_n = RX_IDLE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = RX_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: decodes two-byte ASCII drive messages from the UART.
// Ports: clk, reset, uart_in -> command, multiplier, valid, frame_err, cmd_err.
module uart_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_in,
  output logic [2:0] command,
  output logic [2:0] multiplier,
  output logic       valid,
  output logic       frame_err,
  output logic       cmd_err
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int TO  = TIMEOUT_BITS * CPB;
  localparam int TW  = $clog2(TO + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO - 1);
  localparam logic [TW-1:0] T_ONE   = TW'(1);

  logic       [7:0] data;
  logic             byte_valid;

  msg_state_e       mstate;
  msg_state_e       mstate_n;
  drive_cmd_e       pend;
  drive_cmd_e       pend_n;
  logic    [TW-1:0] tcnt;
  logic    [TW-1:0] tcnt_n;
  logic       [2:0] cmd_n;
  logic       [2:0] mult_n;
  logic             valid_n;
  logic             err_n;

  uart_rx_byte #(
    .CLKS_PER_BIT(CPB)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .uart_in   (uart_in),
    .data      (data),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mstate     <= MSG_WAIT_CMD;
      pend       <= CMD_STOP;
      tcnt       <= '0;
      command    <= 3'd0;
      multiplier <= 3'd0;
      valid      <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      mstate     <= mstate_n;
      pend       <= pend_n;
      tcnt       <= tcnt_n;
      command    <= cmd_n;
      multiplier <= mult_n;
      valid      <= valid_n;
      cmd_err    <= err_n;
    end
  end

  // tcnt = cycles since the pending letter arrived, so the
  // timeout strobe lands exactly TO cycles after that byte.
  always_comb begin
    mstate_n = mstate;
    pend_n   = pend;
    tcnt_n   = tcnt;
    cmd_n    = command;
    mult_n   = multiplier;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    unique case (mstate)
      MSG_WAIT_CMD: begin
        tcnt_n = '0;
        if (byte_valid) begin
          if (is_cmd_letter(data)) begin
            pend_n   = ascii_to_cmd(data);
            tcnt_n   = T_ONE;
            mstate_n = MSG_WAIT_MULT;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      MSG_WAIT_MULT: begin
        tcnt_n = tcnt + T_ONE;
        if (frame_err) begin
          tcnt_n   = '0;
          mstate_n = MSG_WAIT_CMD;
        end else if (byte_valid) begin
          unique case (1'b1)
            is_digit(data): begin
              cmd_n    = pend;
              // '0'..'7' share their low three bits with the value
              mult_n   = data[2:0];
              valid_n  = 1'b1;
              tcnt_n   = '0;
              mstate_n = MSG_WAIT_CMD;
            end
            is_cmd_letter(data): begin
              err_n  = 1'b1;
              pend_n = ascii_to_cmd(data);
              tcnt_n = T_ONE;
            end
            default: begin
              err_n    = 1'b1;
              tcnt_n   = '0;
              mstate_n = MSG_WAIT_CMD;
            end
          endcase
        end else if (tcnt == TO_LAST) begin
          err_n    = 1'b1;
          tcnt_n   = '0;
          mstate_n = MSG_WAIT_CMD;
        end
      end
      default: begin
        tcnt_n   = '0;
        mstate_n = MSG_WAIT_CMD;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: scenario tasks plus randomized messages checked
// against a byte-level message model.
module tb_uart_cmd_rx;

  localparam int CPB = 434;
  localparam int TO  = 20 * CPB;
  // start-bit drive cycle -> byte done (stop sample + 1, plus sync)
  localparam int BYTE_DONE = 2 + CPB / 2 + 9 * CPB + 1;
  // start-bit drive cycle -> valid/cmd_err of that byte
  localparam int MSG_LAT = BYTE_DONE + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_in;
  logic [2:0] command;
  logic [2:0] multiplier;
  logic       valid;
  logic       frame_err;
  logic       cmd_err;

  typedef struct packed {
    int         cyc;
    logic [2:0] cmd;
    logic [2:0] mult;
  } vev_t;

  vev_t vq[$];
  int   cq[$];
  int   fq[$];
  int   cyc = 0;
  int   viol = 0;
  int   checks = 0;
  int   errors = 0;
  logic pv = 1'b0;
  logic pc = 1'b0;
  logic pf = 1'b0;

  logic [7:0] letters [5] = '{8'h53, 8'h46, 8'h42, 8'h4C, 8'h52};

  uart_cmd_rx dut (
    .clk       (clk),
    .reset     (reset),
    .uart_in   (uart_in),
    .command   (command),
    .multiplier(multiplier),
    .valid     (valid),
    .frame_err (frame_err),
    .cmd_err   (cmd_err)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      pv = 1'b0;
      pc = 1'b0;
      pf = 1'b0;
    end else begin
      if (valid) vq.push_back('{cyc, command, multiplier});
      if (cmd_err) cq.push_back(cyc);
      if (frame_err) fq.push_back(cyc);
      if ((valid && pv) || (cmd_err && pc) ||
          (frame_err && pf) || (valid && cmd_err))
        viol++;
      pv = valid;
      pc = cmd_err;
      pf = frame_err;
    end
  end

  task automatic clear_events();
    vq.delete();
    cq.delete();
    fq.delete();
  endtask

  task automatic drive_bit(input logic v);
    uart_in = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    uart_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop,
                           output int c0);
    c0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  function automatic int letter_idx(input logic [7:0] b);
    int r;
    r = -1;
    for (int i = 0; i < 5; i++) if (letters[i] == b) r = i;
    return r;
  endfunction

  function automatic logic is_dig(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h37);
  endfunction

  task automatic test_reset();
    checks++;
    if (command !== 3'd0) begin
      errors++; $display("FAIL rst_cmd got %0d exp 0", command);
    end
    checks++;
    if (multiplier !== 3'd0) begin
      errors++; $display("FAIL rst_mult got %0d exp 0", multiplier);
    end
    checks++;
    if ({valid, frame_err, cmd_err} !== 3'b000) begin
      errors++;
      $display("FAIL rst_pulses got %b exp 000",
               {valid, frame_err, cmd_err});
    end
  endtask

  task automatic test_fwd3();
    int c1, c2;
    clear_events();
    send_byte(8'h46, 1'b1, c1);
    send_byte(8'h33, 1'b1, c2);
    idle(20);
    checks++;
    if (vq.size() !== 1) begin
      errors++; $display("FAIL f3_count got %0d exp 1", vq.size());
    end
    if (vq.size() > 0) begin
      checks++;
      if (vq[0].cyc !== c2 + MSG_LAT) begin
        errors++;
        $display("FAIL f3_cycle got %0d exp %0d", vq[0].cyc, c2 + MSG_LAT);
      end
      checks++;
      if (vq[0].cmd !== 3'd1 || vq[0].mult !== 3'd3) begin
        errors++;
        $display("FAIL f3_value got %0d/%0d exp 1/3", vq[0].cmd, vq[0].mult);
      end
    end
    checks++;
    if (cq.size() + fq.size() !== 0) begin
      errors++;
      $display("FAIL f3_errs got %0d exp 0", cq.size() + fq.size());
    end
  endtask

  task automatic test_glitch();
    clear_events();
    uart_in = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    idle(1000);
    checks++;
    if (vq.size() + cq.size() + fq.size() !== 0) begin
      errors++;
      $display("FAIL glitch_events got %0d exp 0",
               vq.size() + cq.size() + fq.size());
    end
    checks++;
    if (command !== 3'd1 || multiplier !== 3'd3) begin
      errors++;
      $display("FAIL glitch_hold got %0d/%0d exp 1/3", command, multiplier);
    end
  endtask

  task automatic test_frame_err();
    int cf, cs, c0;
    clear_events();
    send_byte(8'h46, 1'b0, cf);
    repeat (3 * CPB) @(posedge clk);
    #1;
    checks++;
    if (fq.size() !== 1) begin
      errors++; $display("FAIL fe_count got %0d exp 1", fq.size());
    end
    if (fq.size() > 0) begin
      checks++;
      if (fq[0] !== cf + BYTE_DONE) begin
        errors++;
        $display("FAIL fe_cycle got %0d exp %0d", fq[0], cf + BYTE_DONE);
      end
    end
    checks++;
    if (vq.size() + cq.size() !== 0) begin
      errors++;
      $display("FAIL fe_quiet got %0d exp 0", vq.size() + cq.size());
    end
    idle(2 * CPB);
    clear_events();
    send_byte(8'h53, 1'b1, cs);
    send_byte(8'h30, 1'b1, c0);
    idle(20);
    checks++;
    if (vq.size() !== 1) begin
      errors++; $display("FAIL fe_s0_count got %0d exp 1", vq.size());
    end
    if (vq.size() > 0) begin
      checks++;
      if (vq[0].cmd !== 3'd0 || vq[0].mult !== 3'd0 ||
          vq[0].cyc !== c0 + MSG_LAT) begin
        errors++;
        $display("FAIL fe_s0 got %0d/%0d@%0d exp 0/0@%0d",
                 vq[0].cmd, vq[0].mult, vq[0].cyc, c0 + MSG_LAT);
      end
    end
  endtask

  task automatic test_bad_cmd();
    int cx, cl1, cl2, c7;
    clear_events();
    send_byte(8'h58, 1'b1, cx);
    send_byte(8'h4C, 1'b1, cl1);
    send_byte(8'h4C, 1'b1, cl2);
    send_byte(8'h37, 1'b1, c7);
    idle(20);
    checks++;
    if (cq.size() !== 2) begin
      errors++; $display("FAIL bad_errcount got %0d exp 2", cq.size());
    end
    if (cq.size() == 2) begin
      checks++;
      if (cq[0] !== cx + MSG_LAT || cq[1] !== cl2 + MSG_LAT) begin
        errors++;
        $display("FAIL bad_errcycles got %0d,%0d exp %0d,%0d",
                 cq[0], cq[1], cx + MSG_LAT, cl2 + MSG_LAT);
      end
    end
    checks++;
    if (vq.size() !== 1) begin
      errors++; $display("FAIL bad_validcount got %0d exp 1", vq.size());
    end
    if (vq.size() > 0) begin
      checks++;
      if (vq[0].cmd !== 3'd3 || vq[0].mult !== 3'd7 ||
          vq[0].cyc !== c7 + MSG_LAT) begin
        errors++;
        $display("FAIL bad_l7 got %0d/%0d@%0d exp 3/7@%0d",
                 vq[0].cmd, vq[0].mult, vq[0].cyc, c7 + MSG_LAT);
      end
    end
  endtask

  task automatic test_timeout();
    int cr, c5;
    clear_events();
    send_byte(8'h52, 1'b1, cr);
    idle(BYTE_DONE + TO - 10 * CPB + 20);
    checks++;
    if (cq.size() !== 1) begin
      errors++; $display("FAIL to_count got %0d exp 1", cq.size());
    end
    if (cq.size() > 0) begin
      checks++;
      if (cq[0] !== cr + BYTE_DONE + TO) begin
        errors++;
        $display("FAIL to_cycle got %0d exp %0d", cq[0], cr + BYTE_DONE + TO);
      end
    end
    checks++;
    if (vq.size() !== 0 || command !== 3'd3 || multiplier !== 3'd7) begin
      errors++;
      $display("FAIL to_hold got %0d/%0d n=%0d exp 3/7 n=0",
               command, multiplier, vq.size());
    end
    clear_events();
    send_byte(8'h35, 1'b1, c5);
    idle(20);
    checks++;
    if (cq.size() !== 1 || vq.size() !== 0) begin
      errors++;
      $display("FAIL to_digit got err=%0d val=%0d exp 1/0",
               cq.size(), vq.size());
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    int cb, c2;
    b = 8'h42;
    clear_events();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    uart_in = b[4];
    repeat (CPB / 2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({command, multiplier, valid, frame_err, cmd_err} !== 9'd0) begin
      errors++;
      $display("FAIL midrst_out got %0d/%0d %b exp 0/0 000",
               command, multiplier, {valid, frame_err, cmd_err});
    end
    reset = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #1;
    idle(2 * CPB);
    checks++;
    if (vq.size() + cq.size() + fq.size() !== 0) begin
      errors++;
      $display("FAIL midrst_quiet got %0d exp 0",
               vq.size() + cq.size() + fq.size());
    end
    send_byte(8'h42, 1'b1, cb);
    send_byte(8'h32, 1'b1, c2);
    idle(20);
    checks++;
    if (vq.size() !== 1) begin
      errors++; $display("FAIL midrst_count got %0d exp 1", vq.size());
    end
    if (vq.size() > 0) begin
      checks++;
      if (vq[0].cmd !== 3'd2 || vq[0].mult !== 3'd2 ||
          vq[0].cyc !== c2 + MSG_LAT) begin
        errors++;
        $display("FAIL midrst_b2 got %0d/%0d@%0d exp 2/2@%0d",
                 vq[0].cmd, vq[0].mult, vq[0].cyc, c2 + MSG_LAT);
      end
    end
  endtask

  // Model: a message is a letter followed directly by a digit;
  // every byte that breaks that rule costs one cmd_err.
  task automatic test_random();
    logic [7:0] seq[$];
    logic [7:0] b;
    vev_t       exp_v[$];
    int         exp_err;
    int         have_pend;
    int         pend;
    int         c0;
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 2))
        0: b = letters[$urandom_range(0, 4)];
        1: b = 8'(8'h30 + $urandom_range(0, 7));
        default: begin
          do b = 8'($urandom_range(0, 255));
          while (letter_idx(b) >= 0 || is_dig(b));
        end
      endcase
      seq.push_back(b);
    end
    seq.push_back(8'h30);
    clear_events();
    exp_err = 0;
    have_pend = 0;
    pend = 0;
    foreach (seq[i]) begin
      send_byte(seq[i], 1'b1, c0);
      if (have_pend != 0 && is_dig(seq[i])) begin
        exp_v.push_back('{c0 + MSG_LAT, 3'(pend), 3'(seq[i] - 8'h30)});
        have_pend = 0;
      end else if (letter_idx(seq[i]) >= 0) begin
        if (have_pend != 0) exp_err++;
        pend = letter_idx(seq[i]);
        have_pend = 1;
      end else begin
        exp_err++;
        have_pend = 0;
      end
    end
    idle(20);
    checks++;
    if (cq.size() !== exp_err) begin
      errors++;
      $display("FAIL rnd_errs got %0d exp %0d", cq.size(), exp_err);
    end
    checks++;
    if (vq.size() !== exp_v.size()) begin
      errors++;
      $display("FAIL rnd_count got %0d exp %0d", vq.size(), exp_v.size());
    end else begin
      foreach (exp_v[i]) begin
        checks++;
        if (vq[i] !== exp_v[i]) begin
          errors++;
          $display("FAIL rnd_valid%0d got %0d/%0d@%0d exp %0d/%0d@%0d", i,
                   vq[i].cmd, vq[i].mult, vq[i].cyc,
                   exp_v[i].cmd, exp_v[i].mult, exp_v[i].cyc);
        end
      end
    end
  endtask

  task automatic test_pulses();
    checks++;
    if (viol !== 0) begin
      errors++; $display("FAIL pulse_shape got %0d exp 0", viol);
    end
  endtask

  initial begin
    reset   = 1'b1;
    uart_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    idle(10);
    test_fwd3();
    test_glitch();
    test_frame_err();
    test_bad_cmd();
    test_timeout();
    test_reset_midframe();
    test_random();
    test_pulses();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
